pc_fetch_ctrl: RTL and testbench

- Next-PC and instruction-fetch controller. It sits directly upstream of the 32-bit PC register and drives that register's d_i and en_i.
- It reads the registered PC back and issues fetch requests to instruction memory with a ready handshake.
- It holds the fetched instruction for decode and handles stalls and branch/jump redirects, including redirects that arrive while a fetch is outstanding.

---
 rtl/pc_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Next-PC / instruction-fetch controller driving an external PC register.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects load TRAP_VEC.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
    input  logic        i_clk,
    input  logic        nrst_i,
    input  logic [31:0] pc_q_i,
    output logic [31:0] pc_d_o,
    output logic        pc_en_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_redir_pend;
    logic [31:0] r_redir_tgt;

    logic [31:0] w_tgt_raw;
    logic [31:0] w_tgt;
    logic        w_tgt_bad;
    logic        w_unused;

    // A live redirect always beats the latched one.
    assign w_tgt_raw = redirect_i ? redirect_pc_i : r_redir_tgt;

`ifdef PC_MISALIGN_TRAP_EN
    assign w_tgt_bad = |w_tgt_raw[1:0];
    assign w_tgt     = w_tgt_bad ? TRAP_VEC : w_tgt_raw;
`else
    assign w_tgt_bad = 1'b0;
    assign w_tgt     = {w_tgt_raw[31:2], 2'b00};
`endif

    assign w_unused = ^{RESET_PC, TRAP_VEC};

    assign imem_req_o    = (r_state == REQ);
    assign imem_addr_o   = pc_q_i;
    assign instr_o       = r_instr;
    assign instr_valid_o = r_valid;

    always_comb begin
        pc_en_o    = 1'b0;
        pc_d_o     = 32'h0;
        misalign_o = 1'b0;
        unique case (r_state)
            REQ: begin
                if (imem_ready_i) begin
                    pc_en_o = 1'b1;
                    if (r_redir_pend || redirect_i) begin
                        pc_d_o     = w_tgt;
                        misalign_o = w_tgt_bad;
                    end else begin
                        pc_d_o = pc_q_i + 32'd4;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_en_o    = 1'b1;
                    pc_d_o     = w_tgt;
                    misalign_o = w_tgt_bad;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state      <= BOOT;
            r_instr      <= 32'h0;
            r_valid      <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= 32'h0;
        end else begin
            unique case (r_state)
                BOOT: begin
                    r_state <= REQ;
                    if (redirect_i) begin
                        r_redir_pend <= 1'b1;
                        r_redir_tgt  <= redirect_pc_i;
                    end
                end
                REQ: begin
                    if (imem_ready_i) begin
                        if (r_redir_pend || redirect_i) begin
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_instr <= imem_rdata_i;
                            r_valid <= 1'b1;
                            r_state <= HOLD;
                        end
                    end else if (redirect_i) begin
                        // Request stays outstanding; its data is dropped later.
                        r_redir_pend <= 1'b1;
                        r_redir_tgt  <= redirect_pc_i;
                    end
                end
                HOLD: begin
                    if (redirect_i || !stall_i) begin
                        r_valid <= 1'b0;
                        r_state <= REQ;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural PC register.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

    logic        i_clk;
    logic        nrst_i;
    logic [31:0] pc_q_i;
    logic [31:0] pc_d_o;
    logic        pc_en_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        misalign_o;

    int n_vec;
    int n_err;

    pc_fetch_ctrl #(
        .RESET_PC (32'h0),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .i_clk         (i_clk),
        .nrst_i        (nrst_i),
        .pc_q_i        (pc_q_i),
        .pc_d_o        (pc_d_o),
        .pc_en_o       (pc_en_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .misalign_o    (misalign_o)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always_ff @(posedge i_clk or negedge nrst_i) begin
        if (!nrst_i)      pc_q_i <= 32'h0;
        else if (pc_en_o) pc_q_i <= pc_d_o;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rdata,
                         input logic stl, input logic rd,
                         input logic [31:0] rpc);
        @(negedge i_clk);
        imem_ready_i  = rdy;
        imem_rdata_i  = rdata;
        stall_i       = stl;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #1;
    endtask

    logic [31:0] exp_mis_pc;
    logic        exp_mis;

    initial begin
        n_vec = 0;
        n_err = 0;
        nrst_i = 1'b1;
        imem_ready_i = 1'b0;
        imem_rdata_i = 32'h0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
`ifdef PC_MISALIGN_TRAP_EN
        exp_mis_pc = TRAP_VEC;
        exp_mis    = 1'b1;
`else
        exp_mis_pc = 32'h200;
        exp_mis    = 1'b0;
`endif
        #1 nrst_i = 1'b0;
        #2;
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_en", {31'b0, pc_en_o}, 32'd0);
        check("rst_pcd", pc_d_o, 32'h0);
        check("rst_mis", {31'b0, misalign_o}, 32'd0);

        // Release: BOOT cycle, then back-to-back fetches with ready=1.
        @(negedge i_clk);
        @(negedge i_clk);
        nrst_i = 1'b1;
        imem_ready_i = 1'b1;
        imem_rdata_i = 32'hAAAA_0000;
        #1;
        check("boot_req", {31'b0, imem_req_o}, 32'd0);
        check("boot_en", {31'b0, pc_en_o}, 32'd0);

        drive(1, 32'hAAAA_0000, 0, 0, 0);
        check("f0_req", {31'b0, imem_req_o}, 32'd1);
        check("f0_addr", imem_addr_o, 32'h0);
        check("f0_en", {31'b0, pc_en_o}, 32'd1);
        check("f0_pcd", pc_d_o, 32'h4);
        drive(1, 32'hAAAA_0001, 0, 0, 0);
        check("f0_hold_valid", {31'b0, instr_valid_o}, 32'd1);
        check("f0_instr", instr_o, 32'hAAAA_0000);
        check("f0_hold_req", {31'b0, imem_req_o}, 32'd0);
        check("f0_hold_en", {31'b0, pc_en_o}, 32'd0);
        drive(1, 32'hAAAA_0004, 0, 0, 0);
        check("f1_valid", {31'b0, instr_valid_o}, 32'd0);
        check("f1_addr", imem_addr_o, 32'h4);
        check("f1_pcd", pc_d_o, 32'h8);
        drive(1, 32'h0, 0, 0, 0);
        check("f1_instr", instr_o, 32'hAAAA_0004);
        drive(1, 32'hAAAA_0008, 0, 0, 0);
        check("f2_addr", imem_addr_o, 32'h8);
        check("f2_pcd", pc_d_o, 32'hC);
        drive(1, 32'h0, 0, 0, 0);
        drive(1, 32'hAAAA_000C, 0, 0, 0);
        check("f3_addr", imem_addr_o, 32'hC);
        drive(0, 32'h0, 0, 0, 0);

        // Three wait cycles at PC 0x10.
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 0, 0, 0);
            check("wait_req", {31'b0, imem_req_o}, 32'd1);
            check("wait_addr", imem_addr_o, 32'h10);
            check("wait_en", {31'b0, pc_en_o}, 32'd0);
        end
        drive(1, 32'hDEAD_BEEF, 0, 0, 0);
        check("wait_done_en", {31'b0, pc_en_o}, 32'd1);
        check("wait_done_pcd", pc_d_o, 32'h14);

        // Stall in HOLD for four cycles.
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 1, 0, 0);
            check("stall_instr", instr_o, 32'hDEAD_BEEF);
            check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
            check("stall_en", {31'b0, pc_en_o}, 32'd0);
            check("stall_req", {31'b0, imem_req_o}, 32'd0);
        end
        drive(0, 32'h0, 0, 0, 0);
        check("unstall_req", {31'b0, imem_req_o}, 32'd0);

        // Redirect in the second wait cycle; the late response is dropped.
        drive(0, 32'h0, 0, 0, 0);
        check("post_stall_req", {31'b0, imem_req_o}, 32'd1);
        check("post_stall_addr", imem_addr_o, 32'h14);
        drive(0, 32'h0, 0, 1, 32'h100);
        check("redir_wait_en", {31'b0, pc_en_o}, 32'd0);
        drive(0, 32'h0, 0, 0, 0);
        drive(1, 32'h1234_5678, 0, 0, 0);
        check("redir_ack_en", {31'b0, pc_en_o}, 32'd1);
        check("redir_ack_pcd", pc_d_o, 32'h100);
        drive(1, 32'h0000_0055, 0, 0, 0);
        check("redir_drop_valid", {31'b0, instr_valid_o}, 32'd0);
        check("redir_new_addr", imem_addr_o, 32'h100);
        check("redir_new_pcd", pc_d_o, 32'h104);

        // Redirect in HOLD while stalled.
        drive(0, 32'h0, 1, 1, 32'h200);
        check("hold_redir_en", {31'b0, pc_en_o}, 32'd1);
        check("hold_redir_pcd", pc_d_o, 32'h200);
        drive(1, 32'h0000_000A, 0, 0, 0);
        check("hold_redir_valid", {31'b0, instr_valid_o}, 32'd0);
        check("hold_redir_addr", imem_addr_o, 32'h200);

        // Misaligned redirect target.
        drive(0, 32'h0, 0, 1, 32'h202);
        check("mis_pcd", pc_d_o, exp_mis_pc);
        check("mis_flag", {31'b0, misalign_o}, {31'b0, exp_mis});
        drive(1, 32'h0, 0, 1, 32'h300);
        check("mis_addr", imem_addr_o, exp_mis_pc);
        check("mis_clear", {31'b0, misalign_o}, 32'd0);
        check("req_rdy_redir_pcd", pc_d_o, 32'h300);

        // Last pending redirect wins, then the PC wraps.
        drive(0, 32'h0, 0, 0, 0);
        check("rdy_redir_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rdy_redir_addr", imem_addr_o, 32'h300);
        drive(0, 32'h0, 0, 1, 32'h400);
        drive(0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        drive(1, 32'h0, 0, 0, 0);
        check("last_wins_pcd", pc_d_o, 32'hFFFF_FFFC);
        drive(1, 32'hCAFE_F00D, 0, 0, 0);
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        check("wrap_pcd", pc_d_o, 32'h0);
        drive(0, 32'h0, 1, 0, 0);
        check("wrap_instr", instr_o, 32'hCAFE_F00D);
        check("wrap_pc", pc_q_i, 32'h0);

        // Redirect during BOOT is held until the first response.
        @(negedge i_clk);
        nrst_i = 1'b0;
        #1;
        check("rst2_valid", {31'b0, instr_valid_o}, 32'd0);
        @(negedge i_clk);
        nrst_i = 1'b1;
        imem_ready_i = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        #1;
        check("boot_redir_en", {31'b0, pc_en_o}, 32'd0);
        drive(1, 32'h1111_1111, 0, 0, 0);
        check("boot_redir_pcd", pc_d_o, 32'h40);
        drive(1, 32'h7777_7777, 0, 0, 0);
        check("boot_redir_drop", {31'b0, instr_valid_o}, 32'd0);
        check("boot_redir_addr", imem_addr_o, 32'h40);
        check("boot_redir_next", pc_d_o, 32'h44);
        drive(0, 32'h0, 1, 0, 0);
        check("boot_redir_instr", instr_o, 32'h7777_7777);
        check("boot_redir_v", {31'b0, instr_valid_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
